// File: rtl/apb_bram_port.sv
// APB4 completer driving a single synchronous RAM port with one-cycle read latency.
// Handles word decode, misaligned/out-of-range errors and registered APB responses.
module apb_bram_port #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      apb_psel_i,
  input  logic                      apb_penable_i,
  input  logic                      apb_pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
  input  logic [DATA_WIDTH-1:0]     apb_pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]   apb_pstrb_i,
  output logic                      apb_pready_o,
  output logic [DATA_WIDTH-1:0]     apb_prdata_o,
  output logic                      apb_pslverr_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam int unsigned FieldTop  = MEM_ADDR_WIDTH + OffWidth;
  localparam logic [APB_ADDR_WIDTH-1:0] OffMask = APB_ADDR_WIDTH'((1 << OffWidth) - 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  slverr_q, slverr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic access;
  logic misaligned;
  logic out_of_range;
  logic addr_err;

  assign access       = apb_psel_i & apb_penable_i;
  assign misaligned   = |(apb_paddr_i & OffMask);
  assign out_of_range = |(apb_paddr_i >> FieldTop);
  assign addr_err     = misaligned | out_of_range;

  // Only IDLE issues a request, so a master holding its signals gets exactly one RAM access.
  // Reset also gates it so a held access phase cannot reach the RAM while in reset.
  assign mem_req_o   = rst_ni & (state_q == StIdle) & access & ~addr_err;
  assign mem_we_o    = apb_pwrite_i;
  assign mem_be_o    = apb_pwrite_i ? apb_pstrb_i : {StrbWidth{1'b1}};
  assign mem_addr_o  = apb_paddr_i[FieldTop-1 -: MEM_ADDR_WIDTH];
  assign mem_wdata_o = apb_pwdata_i;

  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (addr_err) begin
            ready_d  = 1'b1;
            slverr_d = 1'b1;
            rdata_d  = '0;
            state_d  = StResp;
          end else if (apb_pwrite_i) begin
            ready_d = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        rdata_d = mem_rdata_i;
        ready_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign apb_pready_o  = ready_q;
  assign apb_pslverr_o = slverr_q;
  assign apb_prdata_o  = rdata_q;

endmodule

// File: tb/tb_apb_bram_port.sv
// Directed bench for apb_bram_port: behavioural RAM behind the port, hand-computed expectations.
module tb_apb_bram_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int dbl_ready = 0;
  logic prev_ready = 1'b0;
  logic [31:0] ram [1024];

  always #5 clk = ~clk;

  apb_bram_port #(
    .APB_ADDR_WIDTH(32),
    .DATA_WIDTH    (32),
    .MEM_ADDR_WIDTH(10)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .apb_psel_i   (psel),
    .apb_penable_i(penable),
    .apb_pwrite_i (pwrite),
    .apb_paddr_i  (paddr),
    .apb_pwdata_i (pwdata),
    .apb_pstrb_i  (pstrb),
    .apb_pready_o (pready),
    .apb_prdata_o (prdata),
    .apb_pslverr_o(pslverr),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  // External RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req) begin
      req_cnt++;
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (pready && prev_ready) dbl_ready++;
    prev_ready = pready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] rd;
  logic        er, rq, we;
  logic [3:0]  be;
  logic [9:0]  ad;
  int          w;

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rq = mem_req; we = mem_we; be = mem_be; ad = mem_addr;
    w = 0;
    while (!pready && w < 16) begin
      w++;
      @(negedge clk);
      #1;
    end
    rd = prdata;
    er = pslverr;
  endtask

  task automatic apb_idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  int snap;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    #12;
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF); apb_idle();
    check("wr_req", 32'(rq), 32'd1);
    check("wr_we", 32'(we), 32'd1);
    check("wr_addr", 32'(ad), 32'd4);
    check("wr_be", 32'(be), 32'hF);
    check("wr_waits", 32'(w), 32'd1);
    check("wr_err", 32'(er), 32'd0);

    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0); apb_idle();
    check("rd_we", 32'(we), 32'd0);
    check("rd_be", 32'(be), 32'hF);
    check("rd_waits", 32'(w), 32'd2);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", 32'(er), 32'd0);

    apb_xfer(1'b1, 32'h0, 32'h11223344, 4'hF); apb_idle();
    apb_xfer(1'b1, 32'h0, 32'hAABBCCDD, 4'h5); apb_idle();
    check("strb_be", 32'(be), 32'h5);
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h0); apb_idle();
    check("strb_rd", rd, 32'h11BB33DD);

    snap = req_cnt;
    apb_xfer(1'b0, 32'h2, 32'h0, 4'hF); apb_idle();
    check("misal_err", 32'(er), 32'd1);
    check("misal_waits", 32'(w), 32'd1);
    check("misal_prdata", rd, 32'd0);
    check("misal_req_t0", 32'(rq), 32'd0);
    apb_xfer(1'b1, 32'h1000, 32'h12345678, 4'hF); apb_idle();
    check("oor_err", 32'(er), 32'd1);
    check("oor_waits", 32'(w), 32'd1);
    check("oor_prdata", rd, 32'd0);
    check("err_req_cnt", 32'(req_cnt - snap), 32'd0);

    snap = req_cnt;
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0);
    check("b2b_rd1", rd, 32'hDEADBEEF);
    apb_xfer(1'b1, 32'h14, 32'h5A5A5A5A, 4'hF);
    check("b2b_wr_waits", 32'(w), 32'd1);
    apb_xfer(1'b0, 32'h14, 32'h0, 4'h0);
    check("b2b_rd2", rd, 32'h5A5A5A5A);
    apb_idle();
    check("b2b_req_cnt", 32'(req_cnt - snap), 32'd3);

    // Reset asserted while the DUT waits on the RAM read.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pready", 32'(pready), 32'd0);
    check("mid_rst_pslverr", 32'(pslverr), 32'd0);
    check("mid_rst_prdata", prdata, 32'd0);
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apb_xfer(1'b0, 32'h14, 32'h0, 4'h0); apb_idle();
    check("post_rst_waits", 32'(w), 32'd2);
    check("post_rst_data", rd, 32'h5A5A5A5A);

    apb_xfer(1'b1, 32'd4092, 32'hCAFEF00D, 4'hF); apb_idle();
    check("last_addr", 32'(ad), 32'd1023);
    check("last_wr_err", 32'(er), 32'd0);
    apb_xfer(1'b0, 32'd4092, 32'h0, 4'h0); apb_idle();
    check("last_rd", rd, 32'hCAFEF00D);
    check("last_rd_err", 32'(er), 32'd0);

    apb_xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0); apb_idle();
    check("zstrb_be", 32'(be), 32'h0);
    check("zstrb_req", 32'(rq), 32'd1);
    check("zstrb_waits", 32'(w), 32'd1);
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0); apb_idle();
    check("zstrb_rd", rd, 32'hDEADBEEF);

    @(negedge clk);
    check("pready_one_cycle", 32'(dbl_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
